// File: rtl/rr_bus_arbiter_8.sv
// rr_bus_arbiter_8
// Round-robin owner sequencer for the shared 16-bit, 8-input result bus.
// Eight level requesters share the bus. The arbiter picks an owner by
// rotating priority, caps each ownership at MAX_HOLD cycles, and inserts
// one idle turnaround cycle after every release.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per ownership (1..255)
// Ports:
//   Clk     in   1  system clock, all state updates on the rising edge
//   Reset   in   1  synchronous active-high reset
//   Req     in   8  level requests, bit i asks for mux input i
//   Sel     out  3  registered mux select (current or last owner)
//   Grant   out  8  registered one-hot grant, zero when nobody owns the bus
//   Valid   out  1  registered, high exactly when Grant != 0
module rr_bus_arbiter_8 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Req,
    output logic [2:0] Sel,
    output logic [7:0] Grant,
    output logic       Valid
);

    localparam int              HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q,    state_d;
    logic [2:0]      ptr_q,      ptr_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [2:0]      sel_q,      sel_d;
    logic [7:0]      grant_q,    grant_d;
    logic            valid_q,    valid_d;

    // Requests rotated so that bit 0 is the highest-priority index (ptr_q).
    // The 3-bit sum wraps naturally mod 8.
    logic [7:0] req_rot;
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
        assign req_rot[gi] = Req[ptr_q + 3'(gi)];
    end

    // Lowest set bit of the rotated vector is the winner's offset from ptr_q.
    logic [2:0] win_off;
    always_comb begin
        win_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = 3'(i);
            end
        end
    end

    logic [2:0] winner;
    assign winner = ptr_q + win_off;

    // Release on owner drop or hold cap; both together still mean one release.
    logic release_now;
    assign release_now = !Req[sel_q] || (hold_cnt_q == HOLD_MAX);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                // Sel deliberately keeps the last owner while idle.
                grant_d = 8'h00;
                valid_d = 1'b0;
                if (Req != 8'h00) begin
                    sel_d      = winner;
                    grant_d    = 8'h01 << winner;
                    valid_d    = 1'b1;
                    hold_cnt_d = HW'(1);
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // Other requesters are ignored here; they compete at the next
                // IDLE pick, where the old owner is demoted to lowest priority.
                if (release_now) begin
                    grant_d    = 8'h00;
                    valid_d    = 1'b0;
                    ptr_d      = sel_q + 3'd1;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 8'h00;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            ptr_q      <= 3'd0;
            hold_cnt_q <= '0;
            sel_q      <= 3'd0;
            grant_q    <= 8'h00;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
        end
    end

    assign Sel   = sel_q;
    assign Grant = grant_q;
    assign Valid = valid_q;

endmodule

// File: doc/rr_bus_arbiter_8.md
# rr_bus_arbiter_8

Round-robin arbiter that shares the 16-bit, 8-input result bus between eight requesters. It sequences the bus by driving the 3-bit select of the 16-bit 8-to-1 mux. It also drives a one-hot grant vector and a bus-valid qualifier. Grants rotate fairly, each grant is capped in length, and one turnaround cycle separates consecutive grants.

## Interface
- MAX_HOLD, default 4: maximum consecutive grant cycles per ownership; legal range 1..255.
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  8  level request, one bit per mux input (bit 0 = input R … bit 7 = input Y).
- Sel  output  3  registered mux select; index of the current or last owner.
- Grant  output  8  registered one-hot grant; all zeros when no owner.
- Valid  output  1  registered; high exactly when Grant != 0; the mux output is meaningful only while Valid = 1.

## Operation
- State registers:
  - state ∈ {IDLE, BUSY}
  - Ptr[2:0]: the highest-priority index for the next pick
  - HoldCnt, width $clog2(MAX_HOLD+1)
  - the Sel, Grant and Valid output registers
- Reset (checked before all else): state=IDLE, Ptr=0, HoldCnt=0, Sel=0, Grant=0, Valid=0. Reset overrides any grant in progress.
- IDLE:
  - If Req == 0, stay in IDLE. Outputs hold Grant=0, Valid=0, and Sel is unchanged.
  - Otherwise the winner is the first set Req bit found searching Ptr, Ptr+1, … mod 8.
  - Next edge: Sel=winner, Grant=1<<winner, Valid=1, HoldCnt=1, state=BUSY.
- BUSY (owner = Sel):
  - Release when Req[Sel]==0 or HoldCnt==MAX_HOLD. On release the next edge sets Grant=0, Valid=0, Ptr=Sel+1 (7 wraps to 0), HoldCnt=0, state=IDLE. Sel keeps the old value.
  - Otherwise HoldCnt increments and the outputs are unchanged.
- The IDLE cycle after every release is mandatory (bus turnaround). No back-to-back grants, even if requests are pending.
- The just-released owner has the lowest priority at the next pick, so a persistent requester cannot starve the others.
- Req bits of non-owners are ignored in BUSY. Those requests are evaluated at the next IDLE.
- If both release conditions are true on the same edge, exactly one release occurs, with identical behaviour.
- MAX_HOLD=1 gives one grant cycle followed by one idle cycle.

## Timing
- Grant latency is 1 cycle. If Req is sampled at edge k in IDLE, Grant, Sel and Valid are visible after edge k.
- A grant lasts min(MAX_HOLD, cycles until Req[Sel] is sampled low) cycles. It is never less than 1 cycle.
- Release latency is 1 edge from sampling the release condition.
- With all eight requesting continuously, each requester gets MAX_HOLD cycles out of every 8·(MAX_HOLD+1).
- Reset asserted at edge k means all outputs are at their reset values after edge k. The first grant is possible at edge k+1 if Reset is low and Req != 0.
- There are no combinational paths from Req to any output.

## Test plan
- Reset with Req=8'hFF held for 3 cycles: Grant=0, Valid=0, Sel=0 throughout. First edge after Reset falls: Sel=0, Grant=8'h01.
- MAX_HOLD=4, single requester Req=8'h08 dropped after 3 grant cycles: Sel=3, Grant=8'h08 and Valid=1 for exactly 3 cycles, then Valid=0, Ptr=4.
- MAX_HOLD=4, Req=8'hFF constant: grant sequence 0,1,2,…,7,0. Each grant lasts 4 cycles, followed by 1 idle cycle, for a 40-cycle rotation.
- Wrap: after owner 6 releases (Ptr=7), Req=8'h81 constant gives grant 7, then idle, then grant 0.
- Reset mid-grant: while Grant=8'h20 with HoldCnt=2, pulse Reset for 1 cycle. Next edge gives Grant=0, Valid=0. With Req=8'h21 afterwards, the grant goes to 0 (Ptr reset), not 5.
- Simultaneous release: MAX_HOLD=2, owner 1 drops Req on the edge where HoldCnt=2, and Req[2] rises during the turnaround cycle. Result: one release, one idle cycle, then Grant=8'h04.
